// File: rtl/isqrt_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_seq_pkg
//  Description : Shared types and constants for the iterative integer
//                square-root responder and its FP64 front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package isqrt_seq_pkg;

  // Default radicand/root width: the FP64 front end feeds a 64-bit fraction.
  localparam int ISQRT_WID_DEFAULT = 64;

  // FP64 field geometry used by the wrapper that forms the significand.
  localparam int FP64_EXP_W  = 11;
  localparam int FP64_FRAC_W = 52;
  localparam int FP64_SIG_W  = 53;
  localparam int FP64_BIAS   = 1023;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the iteration counter: it must hold WID-1.
  function automatic int cnt_width(input int wid);
    return $clog2(wid);
  endfunction

endpackage : isqrt_seq_pkg
`default_nettype wire

// File: rtl/isqrt_seq_step.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_seq_step
//  Description : One restoring radix-2 square-root recurrence step. Purely
//                combinational: brings down the next two radicand bits,
//                trial-subtracts {root, 01} and appends one root bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module isqrt_seq_step #(
  parameter int WID = 64
) (
  // Only the low WID bits of the running remainder can be nonzero between
  // steps (rem <= 2*root), so the upper two bits are not needed here.
  input  logic [WID-1:0] rem,
  input  logic [WID-1:0] root,
  input  logic [1:0]     next2,
  output logic [WID+1:0] rem_n,
  output logic [WID-1:0] root_n
);

  logic [WID+1:0] rem_shift;
  logic [WID+1:0] trial;
  logic           fits;

  // Partial remainder with the next bit pair appended, and the trial divisor.
  always_comb begin
    rem_shift = {rem, next2};
    trial     = {root, 2'b01};
    fits      = (rem_shift >= trial);
    rem_n     = fits ? (rem_shift - trial) : rem_shift;
    root_n    = {root[WID-2:0], fits};
  end

endmodule : isqrt_seq_step
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_seq
//  Description : Iterative integer square root, one root bit per enabled
//                clock. Accepts a WID-bit fraction on an ld pulse and holds
//                o = floor(sqrt(a * 2^WID)) with a sticky inexact flag and a
//                level done until the next accepted ld.
//  Revision    : 1.0 - initial release
// ============================================================================
module isqrt_seq
  import isqrt_seq_pkg::*;
#(
  parameter int WID = ISQRT_WID_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,      // asynchronous, active low
  input  logic           ce,
  input  logic           ld,
  input  logic [WID-1:0] a,
  output logic [WID-1:0] o,
  output logic           rem_nz,
  output logic           busy,
  output logic           done
);

  localparam int CNT_W = cnt_width(WID);
  localparam int REM_W = WID + 2;
  localparam int SR_W  = 2 * WID;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WID - 1);

  // Reject widths the recurrence cannot handle at elaboration time.
  if ((WID < 4) || ((WID % 2) != 0)) begin : g_bad_wid
    $error("isqrt_seq: WID must be even and at least 4");
  end

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WID-1:0]   root_q,   root_d;
  logic [REM_W-1:0] rem_q,    rem_d;
  logic [SR_W-1:0]  sr_q,     sr_d;
  logic [WID-1:0]   o_q,      o_d;
  logic             rem_nz_q, rem_nz_d;

  logic [REM_W-1:0] step_rem;
  logic [WID-1:0]   step_root;

  // One recurrence step fed by the top bit pair of the radicand shifter.
  isqrt_seq_step #(
    .WID (WID)
  ) u_step (
    .rem    (rem_q[WID-1:0]),
    .root   (root_q),
    .next2  (sr_q[SR_W-1 -: 2]),
    .rem_n  (step_rem),
    .root_n (step_root)
  );

  // Next-state logic: load from any state, iterate in RUN, hold otherwise.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    root_d   = root_q;
    rem_d    = rem_q;
    sr_d     = sr_q;
    o_d      = o_q;
    rem_nz_d = rem_nz_q;

    if (ce) begin
      if (ld) begin
        // A load aborts any operation in flight; o keeps its old value.
        state_d  = RUN;
        sr_d     = {a, {WID{1'b0}}};
        root_d   = '0;
        rem_d    = '0;
        cnt_d    = CNT_LOAD;
        rem_nz_d = 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            root_d = step_root;
            rem_d  = step_rem;
            sr_d   = sr_q << 2;
            if (cnt_q == '0) begin
              // Last root bit: publish the result so o is stable while busy.
              state_d  = DONE;
              o_d      = step_root;
              rem_nz_d = |step_rem;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State and datapath registers; ce=0 leaves every _d equal to its _q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      sr_q     <= '0;
      o_q      <= '0;
      rem_nz_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      root_q   <= root_d;
      rem_q    <= rem_d;
      sr_q     <= sr_d;
      o_q      <= o_d;
      rem_nz_q <= rem_nz_d;
    end
  end

  // All outputs come straight from registers.
  assign o      = o_q;
  assign rem_nz = rem_nz_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);

endmodule : isqrt_seq
`default_nettype wire

// File: tb/tb_isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isqrt_seq
//  Description : Self-checking bench for isqrt_seq (WID=64). Stimulus pushes
//                expected results into a scoreboard; a monitor pops and
//                compares whenever done rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_isqrt_seq;

  localparam int WID = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           ce  = 1'b0;
  logic           ld  = 1'b0;
  logic [WID-1:0] a   = '0;
  logic [WID-1:0] o;
  logic           rem_nz;
  logic           busy;
  logic           done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [WID-1:0] o;
    logic           nz;
  } exp_t;

  exp_t sb[$];

  isqrt_seq #(.WID(WID)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .ld     (ld),
    .a      (a),
    .o      (o),
    .rem_nz (rem_nz),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Reference: largest x with x*x <= a*2^64, found by greedy bit trial
  // using full 128-bit multiplication.
  function automatic exp_t ref_model(input logic [WID-1:0] av);
    logic [127:0]   n;
    logic [127:0]   sq;
    logic [WID-1:0] x;
    logic [WID-1:0] c;
    exp_t           e;
    n = {av, 64'h0};
    x = '0;
    for (int b = WID - 1; b >= 0; b--) begin
      c    = x;
      c[b] = 1'b1;
      sq   = {64'h0, c} * {64'h0, c};
      if (sq <= n) x = c;
    end
    sq   = {64'h0, x} * {64'h0, x};
    e.o  = x;
    e.nz = (sq != n);
    return e;
  endfunction

  // ---------------- monitor ----------------
  int           edges = 0;
  logic         mon_ld, mon_ce;
  logic         done_prev  = 1'b0;
  logic         prev_valid = 1'b0;
  logic [66:0]  prev_out;
  exp_t         got;

  always @(posedge clk) begin
    mon_ld = ld;
    mon_ce = ce;
    if (mon_ld && mon_ce) edges = 1;
    else if (mon_ce)      edges = edges + 1;
    #1;
    if (!rst) begin
      prev_valid = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (!mon_ce && prev_valid) begin
        tests++;
        if ({o, rem_nz, busy, done} !== prev_out) begin
          fails++;
          $display("FAIL frozen_on_ce0: got %h required %h", {o, rem_nz, busy, done}, prev_out);
        end
      end
      if (done && !done_prev) begin
        tests++;
        if (edges != WID + 1) begin
          fails++;
          $display("FAIL latency: got %0d enabled edges (incl. load edge) required %0d", edges, WID + 1);
        end
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL busy_in_done: got %b required 0", busy);
        end
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got done with empty scoreboard required no done");
        end else begin
          got = sb.pop_front();
          if (o !== got.o || rem_nz !== got.nz) begin
            fails++;
            $display("FAIL result: got o=%h rem_nz=%b required o=%h rem_nz=%b", o, rem_nz, got.o, got.nz);
          end
        end
      end
      prev_out   = {o, rem_nz, busy, done};
      prev_valid = 1'b1;
      done_prev  = done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_load(input logic [WID-1:0] av, input bit push, input exp_t e);
    @(negedge clk);
    ce = 1'b1;
    ld = 1'b1;
    a  = av;
    if (push) sb.push_back(e);
    @(negedge clk);
    ld = 1'b0;
    a  = {$urandom, $urandom};
  endtask

  task automatic wait_done(input bit rand_ce);
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done) break;
      ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL timeout: got done=%b after %0d cycles required done=1", done, n);
    end
    ce = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    tests++;
    if ({o, rem_nz, busy, done} !== 67'h0) begin
      fails++;
      $display("FAIL %s: got o=%h rem_nz=%b busy=%b done=%b required all 0", name, o, rem_nz, busy, done);
    end
  endtask

  function automatic exp_t mk(input logic [WID-1:0] ov, input logic nz);
    exp_t e;
    e.o  = ov;
    e.nz = nz;
    return e;
  endfunction

  initial begin
    logic [WID-1:0] av;
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    rst = 1'b1;
    ce  = 1'b1;
    repeat (2) @(negedge clk);

    // Directed values with hand-derived results.
    do_load(64'h1, 1'b1, mk(64'h0000_0001_0000_0000, 1'b0));
    wait_done(1'b0);
    do_load(64'h2, 1'b1, mk(64'h0000_0001_6A09_E667, 1'b1));
    wait_done(1'b0);
    do_load(64'h4, 1'b1, mk(64'h0000_0002_0000_0000, 1'b0));
    wait_done(1'b0);
    do_load(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1));
    wait_done(1'b0);
    do_load(64'h0, 1'b1, mk(64'h0, 1'b0));
    wait_done(1'b0);

    // Abort: second load 20 iterations into the first.
    do_load(64'h2, 1'b0, mk(64'h0, 1'b0));
    repeat (19) @(negedge clk);
    do_load(64'h4, 1'b1, mk(64'h0000_0002_0000_0000, 1'b0));
    wait_done(1'b0);
    repeat (5) @(negedge clk);

    // Random clock enable with a=1.
    do_load(64'h1, 1'b1, mk(64'h0000_0001_0000_0000, 1'b0));
    wait_done(1'b1);

    // Asynchronous reset mid-RUN.
    do_load(64'h2, 1'b1, mk(64'h0000_0001_6A09_E667, 1'b1));
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset("async_reset_run");
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    do_load(64'h4, 1'b1, mk(64'h0000_0002_0000_0000, 1'b0));
    wait_done(1'b0);

    // Asynchronous reset while in DONE.
    #2 rst = 1'b0;
    #1 check_reset("async_reset_done");
    @(negedge clk);
    rst = 1'b1;
    do_load(64'h1, 1'b1, mk(64'h0000_0001_0000_0000, 1'b0));
    wait_done(1'b0);

    // Randomized radicands against the reference model.
    for (int i = 0; i < 600; i++) begin
      case (i % 3)
        0:       av = {$urandom, $urandom};
        1:       av = {32'h0, $urandom} >> $urandom_range(0, 31);
        default: av = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      endcase
      do_load(av, 1'b1, ref_model(av));
      wait_done((i % 4) == 0);
    end

    repeat (4) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending results required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got simulation still running required completion");
    $fatal(1, "global timeout");
  end

endmodule : tb_isqrt_seq
`default_nettype wire
